// File: rtl/neural_pkg.sv
// Shared widths, word types and loader state encoding for the neural RAM path.
package neural_pkg;

  localparam int MEM_ADDR_W = 11;
  localparam int MEM_DATA_W = 32;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Host-side control, input stream and RAM write bus of the memory loader.
interface mem_loader_if
  import neural_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  // Host side: issues the load request and streams the words.
  modport master (
    output start, base_addr, word_count, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, checksum
  );

  // Loader side: consumes the stream and drives the RAM write port.
  modport slave (
    input  start, base_addr, word_count, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, checksum
  );

endinterface

// File: rtl/mem_loader.sv
// Streams host words into the weight RAM at consecutive (wrapping) addresses
// and keeps a running additive checksum of everything written.
module mem_loader
  import neural_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  mem_loader_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic [DATA_W-1:0] checksum_p1;

  logic              accept_p0;
  logic              last_p0;

  // Checksum accumulates modulo 2^DATA_W; carries out of the top bit are dropped.
  function automatic logic [DATA_W-1:0] checksum_add(input logic [DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0] word);
    checksum_add = acc + word;
  endfunction

  // Stage p0: acceptance and last-word detection from the current state.
  always_comb begin
    accept_p0 = (state == ST_LOAD) && bus.in_valid;
    last_p0   = (idx == count_q - (ADDR_W+1)'(1));
  end

  // State machine, index bookkeeping and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      idx         <= '0;
      wr_en_p1    <= 1'b0;
      wr_addr_p1  <= '0;
      wr_data_p1  <= '0;
      checksum_p1 <= '0;
    end else begin
      wr_en_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            base_q      <= bus.base_addr;
            count_q     <= bus.word_count;
            idx         <= '0;
            checksum_p1 <= '0;
            state       <= (bus.word_count != '0) ? ST_LOAD : ST_DONE;
          end
        end
        ST_LOAD: begin
          // Stage p1: accepted word becomes a RAM write one cycle later.
          if (accept_p0) begin
            wr_en_p1    <= 1'b1;
            wr_addr_p1  <= base_q + idx[ADDR_W-1:0];
            wr_data_p1  <= bus.in_data;
            checksum_p1 <= checksum_add(checksum_p1, bus.in_data);
            idx         <= idx + (ADDR_W+1)'(1);
            if (last_p0) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == ST_LOAD);
  assign bus.busy     = (state == ST_LOAD);
  assign bus.done     = (state == ST_DONE);
  assign bus.wr_en    = wr_en_p1;
  assign bus.wr_addr  = wr_addr_p1;
  assign bus.wr_data  = wr_data_p1;
  assign bus.checksum = checksum_p1;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: basic, stall, wrap, zero-count, overflow
// and mid-load reset scenarios with hand-computed expectations.
module tb_mem_loader;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_loader_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  mem_loader #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    vectors++;
    if ({bus.in_ready, bus.wr_en, bus.busy, bus.done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.in_ready, bus.wr_en, bus.busy, bus.done});
    end
    vectors++;
    if (bus.wr_addr !== 11'd0 || bus.wr_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_wr: got addr %0h data %0h expected 0/0", bus.wr_addr, bus.wr_data);
    end
    vectors++;
    if (bus.checksum !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_checksum: got %0h expected 0", bus.checksum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [31:0] d [4];
    d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333; d[3] = 32'h44444444;
    bus.start = 1'b1; bus.base_addr = 11'd0; bus.word_count = 12'd4;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_enter_load: got ready %b busy %b expected 1 1", bus.in_ready, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = d[i];
      tick();
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'(i) || bus.wr_data !== d[i] || bus.done !== (i == 3)) begin
        miscompares++;
        $display("FAIL basic_write%0d: got en %b addr %0d data %0h done %b expected 1 %0d %0h %b",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, i, d[i], (i == 3));
      end
    end
    vectors++;
    if (bus.checksum !== 32'hAAAAAAAA || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got sum %0h ready %b busy %b expected aaaaaaaa 0 0",
               bus.checksum, bus.in_ready, bus.busy);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.checksum !== 32'hAAAAAAAA) begin
      miscompares++;
      $display("FAIL basic_after: got en %b done %b sum %0h expected 0 0 aaaaaaaa",
               bus.wr_en, bus.done, bus.checksum);
    end
  endtask

  task automatic test_stalls;
    logic [5:0]  pat;
    logic [10:0] exp_addr;
    int          n_done;
    pat = 6'b101001;  // bit j = in_valid in step j
    exp_addr = 11'h10;
    n_done = 0;
    bus.start = 1'b1; bus.base_addr = 11'h10; bus.word_count = 12'd3;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      bus.in_valid = pat[j]; bus.in_data = 32'h100 + 32'(j);
      tick();
      if (bus.done) n_done++;
      vectors++;
      if (bus.wr_en !== pat[j] || (pat[j] && bus.wr_addr !== exp_addr) ||
          bus.busy !== (j != 5) || bus.done !== (j == 5)) begin
        miscompares++;
        $display("FAIL stall_step%0d: got en %b addr %0h busy %b done %b expected %b %0h %b %b",
                 j, bus.wr_en, bus.wr_addr, bus.busy, bus.done, pat[j], exp_addr, (j != 5), (j == 5));
      end
      if (pat[j]) exp_addr = exp_addr + 11'd1;
    end
    bus.in_valid = 1'b0;
    tick();
    if (bus.done) n_done++;
    vectors++;
    if (bus.checksum !== 32'h308 || n_done != 1 || bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: got sum %0h done_pulses %0d en %b expected 308 1 0",
               bus.checksum, n_done, bus.wr_en);
    end
  endtask

  task automatic test_wrap;
    logic [10:0] a [4];
    a[0] = 11'd2046; a[1] = 11'd2047; a[2] = 11'd0; a[3] = 11'd1;
    bus.start = 1'b1; bus.base_addr = 11'd2046; bus.word_count = 12'd4;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'(i + 1);
      tick();
      vectors++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== a[i] || bus.wr_data !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL wrap_write%0d: got en %b addr %0d data %0h expected 1 %0d %0h",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, a[i], i + 1);
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.checksum !== 32'd10 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_sum: got sum %0d done %b expected 10 1", bus.checksum, bus.done);
    end
    tick();
  endtask

  task automatic test_zero_count;
    bus.start = 1'b1; bus.base_addr = 11'd7; bus.word_count = 12'd0;
    bus.in_valid = 1'b1; bus.in_data = 32'h55;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b1 || bus.wr_en !== 1'b0 || bus.in_ready !== 1'b0 || bus.checksum !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_done: got done %b en %b ready %b sum %0h expected 1 0 0 0",
               bus.done, bus.wr_en, bus.in_ready, bus.checksum);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.wr_en !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after: got done %b en %b ready %b expected 0 0 0",
               bus.done, bus.wr_en, bus.in_ready);
    end
  endtask

  task automatic test_overflow;
    bus.start = 1'b1; bus.base_addr = 11'd5; bus.word_count = 12'd2;
    tick();
    // A second start in LOAD with different parameters must be ignored.
    bus.start = 1'b1; bus.base_addr = 11'd100; bus.word_count = 12'd7;
    bus.in_valid = 1'b1; bus.in_data = 32'hFFFFFFFF;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd5 || bus.checksum !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL ovf_first: got en %b addr %0d sum %0h expected 1 5 ffffffff",
               bus.wr_en, bus.wr_addr, bus.checksum);
    end
    bus.in_data = 32'h00000002;
    tick();
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd6 || bus.checksum !== 32'h00000001 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_second: got en %b addr %0d sum %0h done %b expected 1 6 1 1",
               bus.wr_en, bus.wr_addr, bus.checksum, bus.done);
    end
    bus.in_data = 32'h00000003;
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.checksum !== 32'h00000001 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_extra_word: got en %b sum %0h ready %b expected 0 1 0",
               bus.wr_en, bus.checksum, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.checksum !== 32'h00000001) begin
      miscompares++;
      $display("FAIL ovf_hold: got en %b busy %b sum %0h expected 0 0 1",
               bus.wr_en, bus.busy, bus.checksum);
    end
  endtask

  task automatic test_reset_mid_load;
    int n_bad;
    n_bad = 0;
    bus.start = 1'b1; bus.base_addr = 11'h20; bus.word_count = 12'd8;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hA0 + 32'(i);
      tick();
    end
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'h22 || bus.checksum !== 32'h1E3) begin
      miscompares++;
      $display("FAIL rstmid_pre: got en %b addr %0h sum %0h expected 1 22 1e3",
               bus.wr_en, bus.wr_addr, bus.checksum);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.in_ready, bus.wr_en, bus.busy, bus.done} !== 4'b0000 ||
        bus.wr_addr !== 11'd0 || bus.wr_data !== 32'd0 || bus.checksum !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_reset: got ctrl %b addr %0h data %0h sum %0h expected 0000 0 0 0",
               {bus.in_ready, bus.wr_en, bus.busy, bus.done}, bus.wr_addr, bus.wr_data, bus.checksum);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) n_bad++;
    end
    vectors++;
    if (n_bad != 0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: got %0d cycles with activity expected 0", n_bad);
    end
    // Start coincides with a valid word; only the start is taken.
    bus.start = 1'b1; bus.base_addr = 11'h7FF; bus.word_count = 12'd1;
    bus.in_valid = 1'b1; bus.in_data = 32'h12345678;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_start: got en %b busy %b expected 0 1", bus.wr_en, bus.busy);
    end
    bus.in_data = 32'hDEADBEEF;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'h7FF || bus.wr_data !== 32'hDEADBEEF ||
        bus.done !== 1'b1 || bus.checksum !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rstmid_reload: got en %b addr %0h data %0h done %b sum %0h expected 1 7ff deadbeef 1 deadbeef",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.checksum);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_stalls();
    test_wrap();
    test_zero_count();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
